// File: rtl/vedic_mul_pkg.sv
// Shared types and helpers for the vedic multiplier arbiter slice.
// Combinational helpers only; no state lives here.
package vedic_mul_pkg;

    localparam int WIDTH   = 8;
    localparam int PRODW   = 2 * WIDTH;
    localparam int BUS_MAX = 256;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        IDLE  = 2'd2
    } state_t;

    // Extract operand idx of width w from a packed bus; caller keeps the low w bits.
    function automatic logic [BUS_MAX-1:0] slice_operand(
        input logic [BUS_MAX-1:0] bus,
        input int                 idx,
        input int                 w
    );
        logic [BUS_MAX-1:0] mask;
        mask = (BUS_MAX'(1) << w) - BUS_MAX'(1);
        return (bus >> (idx * w)) & mask;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from ptr_i, with encoded index.
// Latency 0 (purely combinational); no grant while en_i is low.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic            en_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            vld_o
);

    int j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr_i) + k) % NREQ;
            if (en_i && !vld_o && req_i[j]) begin
                gnt_o[j] = 1'b1;
                idx_o    = IDW'(j);
                vld_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vedic_mul_arbiter.sv
// Shares one pipelined multiplier core among NREQ requesters with RR arbitration and an in-order tag FIFO.
// Latency: issue 1 cycle after grant, response 1 cycle after mul_done; grants stop at MAX_OUT in flight or on flush.
module vedic_mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int MAX_OUT = 8,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ*WIDTH-1:0]        req_a,
    input  logic [NREQ*WIDTH-1:0]        req_b,
    output logic [NREQ-1:0]              req_ready,
    input  logic                         flush,
    output logic                         flush_done,
    output logic [WIDTH-1:0]             mul_a,
    output logic [WIDTH-1:0]             mul_b,
    output logic                         mul_do,
    input  logic [2*WIDTH-1:0]           mul_result,
    input  logic                         mul_done,
    output logic                         rsp_valid,
    output logic [IDW-1:0]               rsp_id,
    output logic [2*WIDTH-1:0]           rsp_result,
    output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
    output logic                         err_spurious
);
    import vedic_mul_pkg::*;

    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int AW = $clog2(MAX_OUT);

    state_t                state_q;
    logic [IDW-1:0]        ptr_q, ptr_d;
    logic [CW-1:0]         outstanding_q, outstanding_d;
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [IDW-1:0]        tag_mem_q [MAX_OUT];
    logic [WIDTH-1:0]      mul_a_q, mul_b_q;
    logic                  mul_do_q;
    logic                  rsp_valid_q;
    logic [IDW-1:0]        rsp_id_q;
    logic [2*WIDTH-1:0]    rsp_result_q;
    logic                  flush_done_q;
    logic                  err_q;

    logic                  grant_en, push, pop;
    logic [NREQ-1:0]       gnt;
    logic [IDW-1:0]        gnt_idx;
    logic [BUS_MAX-1:0]    a_sel, b_sel;

    // Uses the registered count only, so a same-cycle pop never frees a slot early.
    assign grant_en = !reset && (state_q == RUN) && !flush && (outstanding_q < CW'(MAX_OUT));

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .req_i (req_valid),
        .en_i  (grant_en),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .vld_o (push)
    );

    assign req_ready = gnt;
    assign pop       = mul_done && (outstanding_q != '0);

    always_comb begin
        a_sel = slice_operand(BUS_MAX'(req_a), int'(gnt_idx), WIDTH);
        b_sel = slice_operand(BUS_MAX'(req_b), int'(gnt_idx), WIDTH);
        ptr_d = ptr_q;
        if (push)
            ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IDW'(1);
        outstanding_d = outstanding_q;
        case ({push, pop})
            2'b10:   outstanding_d = outstanding_q + CW'(1);
            2'b01:   outstanding_d = outstanding_q - CW'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            tag_mem_q[wr_ptr_q] <= gnt_idx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            ptr_q         <= '0;
            outstanding_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            mul_do_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_result_q  <= '0;
            flush_done_q  <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            case (state_q)
                RUN:     if (flush) state_q <= DRAIN;
                DRAIN:   if (outstanding_q == '0) state_q <= IDLE;
                IDLE:    if (!flush) state_q <= RUN;
                default: state_q <= RUN;
            endcase
            flush_done_q  <= (state_q == DRAIN) && (outstanding_q == '0);
            ptr_q         <= ptr_d;
            outstanding_q <= outstanding_d;
            mul_do_q      <= push;
            if (push) begin
                mul_a_q  <= a_sel[WIDTH-1:0];
                mul_b_q  <= b_sel[WIDTH-1:0];
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            rsp_valid_q <= pop;
            if (pop) begin
                rsp_id_q     <= tag_mem_q[rd_ptr_q];
                rsp_result_q <= mul_result;
                rd_ptr_q     <= rd_ptr_q + AW'(1);
            end
            if (mul_done && (outstanding_q == '0))
                err_q <= 1'b1;
        end
    end

    assign mul_a        = mul_a_q;
    assign mul_b        = mul_b_q;
    assign mul_do       = mul_do_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_result   = rsp_result_q;
    assign outstanding  = outstanding_q;
    assign flush_done   = flush_done_q;
    assign err_spurious = err_q;

endmodule

// File: tb/tb_vedic_mul_arbiter.sv
// Bench for vedic_mul_arbiter: behavioural core model plus a queue-based reference of grants and responses.
module tb_vedic_mul_arbiter;

    localparam int S_RUN = 0, S_DRAIN = 1, S_IDLE = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_a, req_b;
    logic [3:0]  req_ready;
    logic        flush, flush_done;
    logic [7:0]  mul_a, mul_b;
    logic        mul_do;
    logic [15:0] mul_result;
    logic        mul_done;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_result;
    logic [3:0]  outstanding;
    logic        err_spurious;

    vedic_mul_arbiter dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .flush(flush), .flush_done(flush_done), .mul_a(mul_a),
        .mul_b(mul_b), .mul_do(mul_do), .mul_result(mul_result), .mul_done(mul_done),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .outstanding(outstanding), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    typedef struct { int id; logic [15:0] p; } tag_t;

    int          n_assert = 0, n_fail = 0;
    int          cyc = 0, lat = 3;
    logic        pend_v [64];
    logic [15:0] pend_r [64];

    // Reference state
    tag_t        tq[$];
    int          m_ptr = 0, m_out = 0, m_state = S_RUN;
    logic        e_do = 0, e_rv = 0, e_fd = 0, e_err = 0, rst_prev = 0;
    logic [7:0]  e_a = 0, e_b = 0;
    logic [1:0]  e_id = 0;
    logic [15:0] e_res = 0;
    int          fd_cnt = 0, dut_max = 0, grants = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic cycle();
        int   g;
        int   j;
        tag_t t;
        int   old_out;
        @(negedge clk);
        g = -1;
        if (!reset && m_state == S_RUN && !flush && m_out < 8)
            for (int k = 0; k < 4; k++) begin
                j = (m_ptr + k) % 4;
                if (g < 0 && req_valid[j]) g = j;
            end
        chk("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
        chk("mul_do", 32'(mul_do), 32'(e_do));
        if (e_do || rst_prev) begin
            chk("mul_a", 32'(mul_a), 32'(e_a));
            chk("mul_b", 32'(mul_b), 32'(e_b));
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        if (e_rv || rst_prev) begin
            chk("rsp_id", 32'(rsp_id), 32'(e_id));
            chk("rsp_result", 32'(rsp_result), 32'(e_res));
        end
        chk("flush_done", 32'(flush_done), 32'(e_fd));
        chk("err_spurious", 32'(err_spurious), 32'(e_err));
        chk("outstanding", 32'(outstanding), 32'(m_out));
        if (flush_done) fd_cnt++;
        if (int'(outstanding) > dut_max) dut_max = int'(outstanding);
        if (g >= 0) grants++;

        // Core model: fixed latency, so completions stay in issue order.
        if (reset) begin
            for (int k = 0; k < 64; k++) pend_v[k] = 1'b0;
        end else if (mul_do) begin
            pend_v[(cyc + lat) % 64] = 1'b1;
            pend_r[(cyc + lat) % 64] = 16'(mul_a) * 16'(mul_b);
        end

        if (reset) begin
            tq.delete();
            m_ptr = 0; m_out = 0; m_state = S_RUN;
            e_do = 0; e_rv = 0; e_fd = 0; e_err = 0;
            e_a = 0; e_b = 0; e_id = 0; e_res = 0;
            rst_prev = 1;
        end else begin
            rst_prev = 0;
            old_out  = m_out;
            e_rv = 0;
            if (mul_done) begin
                if (tq.size() > 0) begin
                    t = tq.pop_front();
                    e_rv = 1; e_id = 2'(t.id); e_res = t.p;
                    m_out--;
                end else begin
                    e_err = 1;
                end
            end
            e_do = (g >= 0);
            if (g >= 0) begin
                e_a = req_a[g*8 +: 8];
                e_b = req_b[g*8 +: 8];
                t.id = g;
                t.p  = 16'(e_a) * 16'(e_b);
                tq.push_back(t);
                m_out++;
                m_ptr = (g + 1) % 4;
            end
            e_fd = (m_state == S_DRAIN) && (old_out == 0);
            case (m_state)
                S_RUN:   if (flush) m_state = S_DRAIN;
                S_DRAIN: if (old_out == 0) m_state = S_IDLE;
                default: if (!flush) m_state = S_RUN;
            endcase
        end

        @(posedge clk);
        #1;
        cyc++;
        mul_done   = pend_v[cyc % 64];
        mul_result = pend_v[cyc % 64] ? pend_r[cyc % 64] : 16'($urandom);
        pend_v[cyc % 64] = 1'b0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic set_ops_all(input logic [7:0] a, input logic [7:0] b);
        for (int k = 0; k < 4; k++) begin
            req_a[k*8 +: 8] = a;
            req_b[k*8 +: 8] = b;
        end
    endtask

    task automatic rand_ops();
        req_a = $urandom;
        req_b = $urandom;
    endtask

    int fd_before;

    initial begin
        for (int k = 0; k < 64; k++) begin pend_v[k] = 1'b0; pend_r[k] = '0; end
        reset = 1; req_valid = 0; req_a = 0; req_b = 0; flush = 0;
        mul_done = 0; mul_result = 0;
        run(3);
        reset = 0;
        run(1);

        // Requesters 0 and 2 contend with FF*FF
        lat = 3;
        set_ops_all(8'hFF, 8'hFF);
        req_valid = 4'b0101;
        run(12);
        req_valid = 0;
        run(8);

        // All requesters, core slower than the in-flight limit
        lat = 20;
        dut_max = 0;
        req_valid = 4'b1111;
        for (int k = 0; k < 40; k++) begin rand_ops(); cycle(); end
        chk("out_saturate", 32'(dut_max), 32'd8);
        req_valid = 0;
        run(30);

        // Single request from requester 3: 12*13
        lat = 4;
        req_a[24 +: 8] = 8'd12;
        req_b[24 +: 8] = 8'd13;
        req_valid = 4'b1000;
        cycle();
        req_valid = 0;
        run(8);

        // Random traffic with a short core latency
        lat = 2 + int'($urandom_range(3));
        for (int k = 0; k < 60; k++) begin
            req_valid = 4'($urandom);
            rand_ops();
            cycle();
        end
        req_valid = 0;
        run(10);

        // Flush with 5 in flight
        lat = 10;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin rand_ops(); cycle(); end
        chk("pre_flush_out", 32'(outstanding), 32'd5);
        flush = 1;
        grants = 0;
        fd_before = fd_cnt;
        run(20);
        chk("flush_no_grant", 32'(grants), 32'd0);
        chk("flush_done_once", 32'(fd_cnt - fd_before), 32'd1);
        flush = 0;
        run(4);
        req_valid = 0;
        run(14);

        // Spurious completion with an empty FIFO
        mul_done = 1; mul_result = 16'hBEEF;
        cycle();
        run(3);
        chk("err_sticky", 32'(err_spurious), 32'd1);

        // Reset with 3 in flight
        lat = 10;
        req_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin rand_ops(); cycle(); end
        chk("pre_reset_out", 32'(outstanding), 32'd3);
        req_valid = 0;
        reset = 1;
        cycle();
        reset = 0;
        req_valid = 4'b1111;
        rand_ops();
        #1;
        chk("post_rst_gnt", 32'(req_ready), 32'b0001);
        cycle();
        req_valid = 0;
        run(15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
